// File: rtl/event_packetizer.sv
// event_packetizer: turns one detector event into a byte packet for a UART.
// Build option: define PACKET_CHECKSUM_EN to append a modulo-256 checksum byte.
module event_packetizer #(
    parameter int N_CH = 2,
    parameter int N_T  = 32,
    parameter int N_P  = 12,
    parameter int N_A  = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_T-1:0]        time_event,
    input  logic signed [N_P-1:0] A_peak_event [N_CH],
    input  logic signed [N_A-1:0] A_area_event [N_CH],
    input  logic                  DAQ_pulse,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [15:0]           dropped_count
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);

`ifdef PACKET_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, HEADER, TIME, PEAK, AREA, CHECKSUM
    } state_t;
    localparam state_t LAST = CHECKSUM;
`else
    typedef enum logic [2:0] {
        IDLE, HEADER, TIME, PEAK, AREA
    } state_t;
    localparam state_t LAST = AREA;
`endif

    state_t state, state_nx;

    logic [1:0]            byte_cnt;
    logic [CW-1:0]         ch_cnt;
    logic [N_T-1:0]        time_q;
    logic signed [N_P-1:0] peak_q [N_CH];
    logic signed [N_A-1:0] area_q [N_CH];

    logic        hs;
    logic        last_ch;
    logic        state_done;
    logic        ch_step;
    logic        pkt_done;
    logic        accept;
    logic        drop;
    logic [31:0] time_ext;
    logic [15:0] peak_ext;
    logic [23:0] area_ext;

    assign hs       = tx_valid && tx_ready;
    assign last_ch  = (ch_cnt == CH_LAST);
    assign pkt_done = hs && state_done && (state == LAST);
    // A pulse on the final handshake starts the next packet back-to-back.
    assign accept   = DAQ_pulse && ((state == IDLE) || pkt_done);
    assign drop     = DAQ_pulse && !accept && (state != IDLE);
    assign ch_step  = ((state == PEAK) && (byte_cnt == 2'd1)) ||
                      ((state == AREA) && (byte_cnt == 2'd2));

    always_comb begin
        unique case (state)
            HEADER:   state_done = 1'b1;
            TIME:     state_done = (byte_cnt == 2'd3);
            PEAK:     state_done = last_ch && (byte_cnt == 2'd1);
            AREA:     state_done = last_ch && (byte_cnt == 2'd2);
`ifdef PACKET_CHECKSUM_EN
            CHECKSUM: state_done = 1'b1;
`endif
            default:  state_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = HEADER;
        else if (hs && state_done) begin
            unique case (state)
                HEADER:  state_nx = TIME;
                TIME:    state_nx = PEAK;
                PEAK:    state_nx = AREA;
`ifdef PACKET_CHECKSUM_EN
                AREA:    state_nx = CHECKSUM;
`endif
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            ch_cnt   <= '0;
        end else if (hs) begin
            if (state_done) begin
                byte_cnt <= '0;
                ch_cnt   <= '0;
            end else if (ch_step) begin
                byte_cnt <= '0;
                ch_cnt   <= ch_cnt + CW'(1);
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                peak_q[i] <= '0;
                area_q[i] <= '0;
            end
        end else if (accept) begin
            time_q <= time_event;
            for (int i = 0; i < N_CH; i++) begin
                peak_q[i] <= A_peak_event[i];
                area_q[i] <= A_area_event[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            dropped_count <= '0;
        else if (drop && (dropped_count != 16'hFFFF))
            dropped_count <= dropped_count + 16'd1;
    end

`ifdef PACKET_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (reset || accept)
            csum <= '0;
        else if (hs)
            csum <= csum + tx_data;
    end
`endif

    always_comb begin
        time_ext = 32'(time_q);
        peak_ext = 16'(peak_q[ch_cnt]);
        area_ext = 24'(area_q[ch_cnt]);
        tx_valid = (state != IDLE);
        busy     = (state != IDLE);
        tx_data  = 8'h00;
        unique case (1'b1)
            (state == HEADER): tx_data = 8'hAA;
            (state == TIME): begin
                unique case (byte_cnt)
                    2'd0: tx_data = time_ext[31:24];
                    2'd1: tx_data = time_ext[23:16];
                    2'd2: tx_data = time_ext[15:8];
                    2'd3: tx_data = time_ext[7:0];
                endcase
            end
            (state == PEAK):
                tx_data = byte_cnt[0] ? peak_ext[7:0] : peak_ext[15:8];
            (state == AREA): begin
                unique case (byte_cnt)
                    2'd0:    tx_data = area_ext[23:16];
                    2'd1:    tx_data = area_ext[15:8];
                    default: tx_data = area_ext[7:0];
                endcase
            end
`ifdef PACKET_CHECKSUM_EN
            (state == CHECKSUM): tx_data = csum;
`endif
            default: tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_event_packetizer.sv
// tb_event_packetizer: random and directed checks of event_packetizer
// against a byte-level packet model.
module tb_event_packetizer;

    localparam int N_CH = 2;
    localparam int N_T  = 32;
    localparam int N_P  = 12;
    localparam int N_A  = 20;
`ifdef PACKET_CHECKSUM_EN
    localparam int PKT_LEN = 5 + 5 * N_CH + 1;
`else
    localparam int PKT_LEN = 5 + 5 * N_CH;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [N_T-1:0]        time_event = '0;
    logic signed [N_P-1:0] A_peak_event [N_CH];
    logic signed [N_A-1:0] A_area_event [N_CH];
    logic                  DAQ_pulse = 1'b0;
    logic                  tx_ready = 1'b0;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  busy;
    logic [15:0]           dropped_count;

    int total = 0;
    int bad = 0;
    int drops_exp = 0;
    byte unsigned rx[$];
    byte unsigned exp_q[$];
    byte unsigned exp_a[$];
    byte unsigned golden [16] = '{
        8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'h00,
        8'h7F, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h34
    };

    event_packetizer #(
        .N_CH(N_CH), .N_T(N_T), .N_P(N_P), .N_A(N_A)
    ) dut (
        .clk(clk),
        .reset(reset),
        .time_event(time_event),
        .A_peak_event(A_peak_event),
        .A_area_event(A_area_event),
        .DAQ_pulse(DAQ_pulse),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Record handshaken bytes; a stalled byte must stay put.
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(tx_valid), 64'd1);
                check("hold_data", 64'(tx_data), 64'(data_prev));
            end
            if (tx_valid && tx_ready)
                rx.push_back(tx_data);
            stall_prev = tx_valid && !tx_ready;
            data_prev = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_event();
        time_event = N_T'($urandom);
        for (int i = 0; i < N_CH; i++) begin
            A_peak_event[i] = N_P'($urandom);
            A_area_event[i] = N_A'($urandom);
        end
    endtask

    task automatic directed_event();
        time_event = N_T'(32'h12345678);
        A_peak_event[0] = N_P'(12'hFFF);
        A_peak_event[1] = N_P'(12'h07F);
        A_area_event[0] = N_A'(20'h80000);
        A_area_event[1] = N_A'(20'h00001);
    endtask

    // Packet model: two's-complement widening done with plain arithmetic.
    task automatic make_exp();
        longint t;
        longint v;
        int sum;
        logic [N_P-1:0] rp;
        logic [N_A-1:0] ra;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        t = longint'(time_event);
        for (int k = 3; k >= 0; k--)
            exp_q.push_back(8'((t / (longint'(1) << (8 * k))) % 256));
        for (int i = 0; i < N_CH; i++) begin
            rp = A_peak_event[i];
            v = longint'(rp);
            if (v >= (longint'(1) << (N_P - 1)))
                v = v - (longint'(1) << N_P);
            v = (v + 65536) % 65536;
            exp_q.push_back(8'(v / 256));
            exp_q.push_back(8'(v % 256));
        end
        for (int i = 0; i < N_CH; i++) begin
            ra = A_area_event[i];
            v = longint'(ra);
            if (v >= (longint'(1) << (N_A - 1)))
                v = v - (longint'(1) << N_A);
            v = (v + 16777216) % 16777216;
            exp_q.push_back(8'(v / 65536));
            exp_q.push_back(8'((v / 256) % 256));
            exp_q.push_back(8'(v % 256));
        end
`ifdef PACKET_CHECKSUM_EN
        sum = 0;
        foreach (exp_q[i])
            sum = sum + int'(exp_q[i]);
        exp_q.push_back(8'(sum % 256));
`else
        sum = 0;
`endif
    endtask

    task automatic expect_packet(input string tag, input byte unsigned want[$]);
        check({tag, "_len"}, 64'(rx.size()), 64'(PKT_LEN));
        for (int i = 0; i < PKT_LEN && i < rx.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 64'(rx[i]), 64'(want[i]));
        rx.delete();
    endtask

    task automatic wait_bytes(input int n);
        int cyc = 0;
        while (rx.size() < n && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    // mode 0: ready high, 1: ready 1-0-1-0, 2: random ready
    task automatic send_packet(input string tag, input int mode,
                               input int npulse);
        int pulses = npulse;
        int cyc = 0;
        rx.delete();
        DAQ_pulse = 1'b1;
        tx_ready = 1'b1;
        tick();
        DAQ_pulse = 1'b0;
        check({tag, "_lat_valid"}, 64'(tx_valid), 64'd1);
        check({tag, "_lat_hdr"}, 64'(tx_data), 64'hAA);
        check({tag, "_busy_on"}, 64'(busy), 64'd1);
        while (rx.size() < PKT_LEN && cyc < 1000) begin
            if (mode == 0)
                tx_ready = 1'b1;
            else if (mode == 1)
                tx_ready = (cyc % 2 == 0);
            else
                tx_ready = 1'($urandom_range(0, 1));
            DAQ_pulse = 1'b0;
            if (!tx_ready && pulses > 0 &&
                (mode == 1 || $urandom_range(0, 2) == 0)) begin
                DAQ_pulse = 1'b1;
                pulses--;
                drops_exp++;
                rand_event();
            end
            tick();
            cyc++;
        end
        DAQ_pulse = 1'b0;
        tx_ready = 1'b1;
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
        check({tag, "_valid_off"}, 64'(tx_valid), 64'd0);
        check({tag, "_drops"}, 64'(dropped_count), 64'(drops_exp));
        expect_packet(tag, exp_q);
    endtask

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            A_peak_event[i] = '0;
            A_area_event[i] = '0;
        end
        reset = 1'b1;
        DAQ_pulse = 1'b1;
        repeat (3) tick();
        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_data", 64'(tx_data), 64'h00);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drops", 64'(dropped_count), 64'd0);
        reset = 1'b0;
        DAQ_pulse = 1'b0;

        // ready high while idle does nothing
        tx_ready = 1'b1;
        repeat (3) tick();
        check("idle_valid", 64'(tx_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // directed event, ready held high, byte per cycle
        directed_event();
        rx.delete();
        DAQ_pulse = 1'b1;
        tick();
        DAQ_pulse = 1'b0;
        for (int i = 0; i < PKT_LEN; i++) begin
            check($sformatf("dir_valid[%0d]", i), 64'(tx_valid), 64'd1);
            check($sformatf("dir_byte[%0d]", i), 64'(tx_data), 64'(golden[i]));
            tick();
        end
        check("dir_busy_after", 64'(busy), 64'd0);
        check("dir_valid_after", 64'(tx_valid), 64'd0);
        rx.delete();

        // same event, ready toggling, three drops during the packet
        directed_event();
        exp_q.delete();
        for (int i = 0; i < PKT_LEN; i++)
            exp_q.push_back(golden[i]);
        send_packet("toggle", 1, 3);
        check("toggle_drop3", 64'(dropped_count), 64'd3);

        // random events, random backpressure, random drops
        for (int n = 0; n < 12; n++) begin
            rand_event();
            make_exp();
            send_packet($sformatf("rnd%0d", n), 2, $urandom_range(0, 3));
        end

        // pulse on the final handshake starts the next packet at once
        rand_event();
        make_exp();
        exp_a = exp_q;
        rx.delete();
        tx_ready = 1'b1;
        DAQ_pulse = 1'b1;
        tick();
        DAQ_pulse = 1'b0;
        wait_bytes(PKT_LEN - 1);
        rand_event();
        make_exp();
        DAQ_pulse = 1'b1;
        tick();
        DAQ_pulse = 1'b0;
        expect_packet("coinA", exp_a);
        check("coin_valid", 64'(tx_valid), 64'd1);
        check("coin_hdr", 64'(tx_data), 64'hAA);
        check("coin_busy", 64'(busy), 64'd1);
        check("coin_drops", 64'(dropped_count), 64'(drops_exp));
        wait_bytes(PKT_LEN);
        expect_packet("coinB", exp_q);
        check("coinB_busy_off", 64'(busy), 64'd0);

        // 70000 drops while stalled on the header saturate the counter
        rand_event();
        make_exp();
        rx.delete();
        tx_ready = 1'b0;
        DAQ_pulse = 1'b1;
        tick();
        rand_event();
        for (int i = 0; i < 70000; i++)
            tick();
        DAQ_pulse = 1'b0;
        check("sat_drops", 64'(dropped_count), 64'hFFFF);
        check("sat_stall", 64'(tx_data), 64'hAA);
        tx_ready = 1'b1;
        wait_bytes(PKT_LEN);
        expect_packet("sat_pkt", exp_q);

        // reset after the sixth byte aborts the packet
        rand_event();
        rx.delete();
        DAQ_pulse = 1'b1;
        tick();
        DAQ_pulse = 1'b0;
        wait_bytes(6);
        check("abort_bytes", 64'(rx.size()), 64'd6);
        reset = 1'b1;
        DAQ_pulse = 1'b1;
        tick();
        reset = 1'b0;
        DAQ_pulse = 1'b0;
        check("abort_valid", 64'(tx_valid), 64'd0);
        check("abort_data", 64'(tx_data), 64'h00);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_drops", 64'(dropped_count), 64'd0);
        tick();
        check("abort_pulse_ignored", 64'(tx_valid), 64'd0);
        drops_exp = 0;
        rand_event();
        make_exp();
        send_packet("post_rst", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
